branch_seq_ctrl: RTL and testbench

//   Multicycle sequencer for conditional/unconditional branches. Time-shares the datapath ALU:

---
 rtl/branch_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_branch_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_seq_ctrl.sv
// Branch sequencer. It time-shares the datapath ALU in two steps: first it computes the
// branch target, then it compares rs with rt. It resolves taken/not-taken, issues a
// one-cycle PC write, and keeps saturating statistics of the outcomes.
module branch_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       br_type,
  input  logic [15:0]      imm,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_src_a_sel,
  output logic             alu_src_b_sel,
  output logic [2:0]       alu_op,
  output logic             pc_write,
  output logic [WIDTH-1:0] pc_next,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nt_cnt
);

  typedef enum logic [2:0] {StIdle, StTgt, StCmp, StCommit, StErr} state_e;

  localparam logic [1:0] BrBne  = 2'b01;
  localparam logic [1:0] BrJmp  = 2'b10;
  localparam logic [1:0] BrRsvd = 2'b11;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;

  state_e           state_q, state_d;
  logic [1:0]       br_q, br_d;
  logic [15:0]      imm_q, imm_d;
  logic [WIDTH-1:0] pc_next_q, pc_next_d;
  logic             taken_q, taken_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] nt_cnt_q, nt_cnt_d;
  logic             ne;

  // The datapath feeds the offset into the ALU from its own immediate path. The latched copy
  // is kept only so that it stays visible for debug.
  logic unused_imm_q;
  assign unused_imm_q = ^imm_q;

  assign ne = |alu_result;

  // Next-state logic. taken/illegal change only on the edge that enters a done state, so
  // they hold their value until the next done.
  always_comb begin
    state_d     = state_q;
    br_d        = br_q;
    imm_d       = imm_q;
    pc_next_d   = pc_next_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    taken_cnt_d = taken_cnt_q;
    nt_cnt_d    = nt_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          br_d  = br_type;
          imm_d = imm;
          if (br_type == BrRsvd) begin
            state_d   = StErr;
            taken_d   = 1'b0;
            illegal_d = 1'b1;
          end else begin
            state_d = StTgt;
          end
        end
      end
      StTgt: begin
        pc_next_d = alu_result;
        if (br_q == BrJmp) begin
          state_d   = StCommit;
          taken_d   = 1'b1;
          illegal_d = 1'b0;
        end else begin
          state_d = StCmp;
        end
      end
      StCmp: begin
        taken_d   = (br_q == BrBne) ? ne : ~ne;
        illegal_d = 1'b0;
        state_d   = StCommit;
      end
      StCommit: begin
        if (taken_q) begin
          if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end else begin
          if (nt_cnt_q != '1) nt_cnt_d = nt_cnt_q + CNT_W'(1);
        end
        state_d = StIdle;
      end
      StErr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs. The ALU selects keep their target-add defaults outside the compare step.
  always_comb begin
    alu_src_a_sel = 1'b0;
    alu_src_b_sel = 1'b1;
    alu_op        = AluAdd;
    done          = 1'b0;
    pc_write      = 1'b0;
    busy          = (state_q != StIdle);
    unique case (state_q)
      StCmp: begin
        alu_src_a_sel = 1'b1;
        alu_src_b_sel = 1'b0;
        alu_op        = AluSub;
      end
      StCommit: begin
        done     = 1'b1;
        pc_write = taken_q;
      end
      StErr:   done = 1'b1;
      default: ;
    endcase
  end

  // State registers with synchronous reset; a reset abandons any in-flight branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      br_q        <= 2'b00;
      imm_q       <= 16'h0000;
      pc_next_q   <= '0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      taken_cnt_q <= '0;
      nt_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      br_q        <= br_d;
      imm_q       <= imm_d;
      pc_next_q   <= pc_next_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
      taken_cnt_q <= taken_cnt_d;
      nt_cnt_q    <= nt_cnt_d;
    end
  end

  assign pc_next   = pc_next_q;
  assign taken     = taken_q;
  assign illegal   = illegal_q;
  assign taken_cnt = taken_cnt_q;
  assign nt_cnt    = nt_cnt_q;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Bench for branch_seq_ctrl. It models the datapath ALU around the DUT, applies a table of
// directed branches and a few hand-written sequences, then runs random branches that are
// checked against a transaction-level model.
module tb_branch_seq_ctrl;

  localparam int unsigned CNT_W = 2;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  br_type;
  logic [15:0] imm;
  logic [31:0] alu_result;
  logic        alu_src_a_sel, alu_src_b_sel;
  logic [2:0]  alu_op;
  logic        pc_write, busy, done, taken, illegal;
  logic [31:0] pc_next;
  logic [CNT_W-1:0] taken_cnt, nt_cnt;

  // Datapath registers seen by the ALU model.
  logic [31:0] pc4, rs, rt;
  logic [15:0] dp_imm;
  logic [31:0] opa, opb;

  int n_vec = 0;
  int n_bad = 0;

  // Model state.
  logic [31:0] model_pc;
  int          model_tc, model_nc;

  always #5 clk = ~clk;

  branch_seq_ctrl #(.WIDTH(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .br_type(br_type), .imm(imm),
    .alu_result(alu_result), .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel),
    .alu_op(alu_op), .pc_write(pc_write), .pc_next(pc_next), .busy(busy), .done(done),
    .taken(taken), .illegal(illegal), .taken_cnt(taken_cnt), .nt_cnt(nt_cnt)
  );

  // Combinational ALU driven by the DUT's select lines.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    opa = alu_src_a_sel ? rs : pc4;
    opb = alu_src_b_sel ? ({{16{dp_imm[15]}}, dp_imm} << 2) : rt;
    case (alu_op)
      3'b010:  alu_result = opa + opb;
      3'b110:  alu_result = opa - opb;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_pcw"}, 32'(pc_write), 32'd0);
    chk({nm, "_taken"}, 32'(taken), 32'd0);
    chk({nm, "_illegal"}, 32'(illegal), 32'd0);
    chk({nm, "_pc_next"}, pc_next, 32'd0);
    chk({nm, "_tcnt"}, 32'(taken_cnt), 32'd0);
    chk({nm, "_ncnt"}, 32'(nt_cnt), 32'd0);
    chk({nm, "_sel"}, 32'({alu_src_a_sel, alu_src_b_sel, alu_op}), 32'b0_1_010);
  endtask

  // Entered on a falling edge; reset is held across one rising edge while start is high.
  task automatic do_reset(input string nm);
    reset = 1'b1;
    start = 1'b1;
    br_type = 2'b10;
    @(negedge clk);
    chk_reset(nm);
    reset = 1'b0;
    start = 1'b0;
    model_pc = 32'd0;
    model_tc = 0;
    model_nc = 0;
  endtask

  // Entered on a falling edge with the DUT idle. Garbage start/br_type/imm are driven while
  // the DUT is busy and must have no effect.
  task automatic run_br(input string nm, input logic [1:0] t, input logic [15:0] im,
                        input logic [31:0] p4, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic e_tk, input logic e_il,
                        input logic [31:0] e_pc);
    logic [4:0] e_sel;
    pc4 = p4;
    rs = a;
    rt = b;
    dp_imm = im;
    start = 1'b1;
    br_type = t;
    imm = im;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (t != 2'b11 && c == 1) e_sel = 5'b0_1_010;
      else if (t[1] == 1'b0 && c == 2) e_sel = 5'b1_0_110;
      else e_sel = 5'b0_1_010;
      chk({nm, "_sel"}, 32'({alu_src_a_sel, alu_src_b_sel, alu_op}), 32'(e_sel));
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      chk({nm, "_done"}, 32'(done), 32'(c == lat));
      chk({nm, "_pcw"}, 32'(pc_write), 32'(c == lat && e_tk));
      if (c == lat) begin
        chk({nm, "_taken"}, 32'(taken), 32'(e_tk));
        chk({nm, "_illegal"}, 32'(illegal), 32'(e_il));
        chk({nm, "_pc_next"}, pc_next, e_pc);
      end
      start = 1'($urandom_range(0, 1));
      br_type = 2'($urandom);
      imm = 16'($urandom);
    end
    model_pc = e_pc;
    if (!e_il) begin
      if (e_tk) model_tc = (model_tc < CMAX) ? model_tc + 1 : CMAX;
      else model_nc = (model_nc < CMAX) ? model_nc + 1 : CMAX;
    end
    @(negedge clk);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    chk({nm, "_idle_done"}, 32'(done), 32'd0);
    chk({nm, "_idle_pcw"}, 32'(pc_write), 32'd0);
    chk({nm, "_hold_taken"}, 32'(taken), 32'(e_tk));
    chk({nm, "_hold_illegal"}, 32'(illegal), 32'(e_il));
    chk({nm, "_tcnt"}, 32'(taken_cnt), 32'(model_tc));
    chk({nm, "_ncnt"}, 32'(nt_cnt), 32'(model_nc));
    start = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  t;
    logic [15:0] im;
    logic [31:0] p4, a, b;
    int          lat;
    logic        tk, il;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [1:0]  t;
    logic [15:0] im;
    logic [31:0] p4, a, b, pc;
    logic        tk, il;
    int          lat;

    tbl[0] = '{"beq_eq",   2'b00, 16'h0004, 32'h100, 32'd5, 32'd5, 3, 1'b1, 1'b0, 32'h110};
    tbl[1] = '{"bne_eq",   2'b01, 16'hFFFE, 32'h100, 32'd5, 32'd5, 3, 1'b0, 1'b0, 32'hF8};
    tbl[2] = '{"jmp",      2'b10, 16'h0010, 32'h40,  32'd1, 32'd2, 2, 1'b1, 1'b0, 32'h80};
    tbl[3] = '{"rsvd",     2'b11, 16'h1234, 32'h40,  32'd1, 32'd2, 1, 1'b0, 1'b1, 32'h80};
    tbl[4] = '{"beq_ne",   2'b00, 16'h7FFF, 32'h0,   32'd7, 32'd3, 3, 1'b0, 1'b0, 32'h1FFFC};
    tbl[5] = '{"bne_ne",   2'b01, 16'h8000, 32'h10,  32'd1, 32'd2, 3, 1'b1, 1'b0,
               32'hFFFE_0010};
    tbl[6] = '{"jmp_wrap", 2'b10, 16'hFFFF, 32'h0,   32'd0, 32'd0, 2, 1'b1, 1'b0,
               32'hFFFF_FFFC};

    reset = 1'b1;
    start = 1'b0;
    br_type = 2'b00;
    imm = 16'h0;
    pc4 = 32'h0;
    rs = 32'h0;
    rt = 32'h0;
    dp_imm = 16'h0;
    model_pc = 32'd0;
    model_tc = 0;
    model_nc = 0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    reset = 1'b0;
    @(negedge clk);

    // Directed table.
    foreach (tbl[i])
      run_br(tbl[i].nm, tbl[i].t, tbl[i].im, tbl[i].p4, tbl[i].a, tbl[i].b, tbl[i].lat,
             tbl[i].tk, tbl[i].il, tbl[i].pc);

    // Saturation: five taken jumps with 2-bit counters must leave taken_cnt at 3.
    do_reset("rst_sat");
    for (int i = 0; i < 5; i++)
      run_br("sat_jmp", 2'b10, 16'h0001, 32'h200, 32'd0, 32'd0, 2, 1'b1, 1'b0, 32'h204);
    chk("sat_taken_cnt", 32'(taken_cnt), 32'd3);
    chk("sat_nt_cnt", 32'(nt_cnt), 32'd0);

    // A reset asserted during the compare step abandons the branch.
    pc4 = 32'h300;
    rs = 32'd9;
    rt = 32'd9;
    dp_imm = 16'h0008;
    start = 1'b1;
    br_type = 2'b00;
    imm = 16'h0008;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("cmp_sel", 32'({alu_src_a_sel, alu_src_b_sel, alu_op}), 32'b1_0_110);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("rst_cmp");
    reset = 1'b0;
    model_pc = 32'd0;
    model_tc = 0;
    model_nc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_pcw", 32'(pc_write), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    // Random branches checked against the transaction-level model.
    for (int i = 0; i < 150; i++) begin
      if (i % 20 == 19) do_reset("rst_rand");
      t = 2'($urandom_range(0, 3));
      im = 16'($urandom);
      p4 = $urandom;
      a = 32'($urandom_range(0, 3));
      b = 32'($urandom_range(0, 3));
      il = (t == 2'b11);
      lat = il ? 1 : (t == 2'b10 ? 2 : 3);
      if (il) tk = 1'b0;
      else if (t == 2'b10) tk = 1'b1;
      else if (t == 2'b00) tk = (a == b);
      else tk = (a != b);
      pc = il ? model_pc : p4 + ({{16{im[15]}}, im} << 2);
      run_br("rand", t, im, p4, a, b, lat, tk, il, pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
